mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative, parametrised HI/LO multiply/divide unit for the five-stage pipelined CPU, adding MULT/MULTU/DIV/DIVU/MTHI/MTLO support. It sits beside the EX-stage ALU. It takes operands after EX forwarding, holds the architectural HI/LO registers, and raises `busy` so the hazard logic can stall any later multiply/divide or HI/LO access until the result commits. A pipeline flush aborts an in-flight operation without touching HI/LO.

## Interface
- `WIDTH`, 32: operand and HI/LO width; ≥ 4.
- `MUL_CYCLES`, 3: multiply latency in cycles; ≥ 1.
- `clk` in 1: the only clock; everything samples on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: issue strobe; `op`, `in_1` and `in_2` are sampled with it.
- `op` in 3: operation code.
  - 000 MULT; 001 MULTU; 010 DIV; 011 DIVU; 100 MTHI; 101 MTLO.
  - 110 and 111 are ignored.
- `in_1` in WIDTH: rs value (multiplicand, dividend, or MTHI/MTLO source).
- `in_2` in WIDTH: rt value (multiplier or divisor).
- `flush` in 1: abort any in-flight operation.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse on the cycle HI/LO commit.
- `div_by_zero` out 1: one-cycle pulse, coincident with `done`, when a DIV or DIVU had divisor 0.
- `hi` out WIDTH: committed HI register.
- `lo` out WIDTH: committed LO register.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **Reset (`reset`=0, asynchronous):** state=IDLE, `hi`=`lo`=0, `busy`=`done`=`div_by_zero`=0, counters and working registers cleared.
- **IDLE transitions** (`start`=1, `flush`=0):
  - MULT/MULTU → MUL.
  - DIV/DIVU with `in_2`≠0 → DIV.
  - DIV/DIVU with `in_2`=0 → commit immediately: `lo`=all-ones, `hi`=`in_1`; pulse `done` and `div_by_zero`; stay IDLE.
  - MTHI/MTLO → write `hi`/`lo` ← `in_1` at this edge, pulse `done`; `busy` is never raised.
- **MUL:**
  - Operands latched; 2·WIDTH product computed (signed for MULT, unsigned for MULTU).
  - A down-counter runs from MUL_CYCLES−1; at 0, `hi`=product[2W−1:W], `lo`=product[W−1:0], pulse `done`, go to IDLE.
- **DIV:**
  - Restoring division, one quotient bit per cycle, WIDTH iterations on magnitudes.
  - For DIV, magnitudes are the absolute values; DIVU uses the raw operands.
  - After the last iteration go to FIX.
- **FIX (1 cycle):**
  - DIV only: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Commit `lo`=quotient and `hi`=remainder, pulse `done`, go to IDLE.
  - Signed min ÷ −1 yields `lo`=min (0x80000000 at W=32) and `hi`=0, with no error flag.
- **`flush`:**
  - From MUL, DIV or FIX: go to IDLE at the next edge; `hi`/`lo` unchanged; no `done`.
  - Flush in the same cycle as `start` in IDLE: `start` is ignored.
  - Flush has priority over a same-cycle commit in FIX: no commit.
- **`start` while busy:** ignored. The hazard unit guarantees this does not occur; the block must still not corrupt state.
- **Ignored ops (110, 111):** no state change, no `done`.

## Timing
- `start` sampled at edge T.
- `busy` is registered: high from T+1 up to and including the commit cycle, low after the commit edge.
- Multiply: commit at edge T+MUL_CYCLES; `done` high for the cycle after that edge.
- Divide: commit at edge T+WIDTH+1 (33 at W=32).
- MTHI/MTLO and divide-by-zero: commit at edge T; `done` high during T→T+1.
- `hi`/`lo` change only on commit edges or on reset; they are directly registered, with no combinational path from inputs.
- Back-to-back issue: a new `start` is accepted in the cycle `done` is high.

## Structure
- Shared package `mdu_pkg`:
  - `op` encodings (`MDU_MULT` … `MDU_MTLO`).
  - State enum.
  - The ALUOp/funct → `op` decode constants used by Control.
- One natural sub-module, `div_iter`: restoring divider datapath (remainder/quotient shift registers, iteration counter, magnitude and sign-fix logic).
- The multiplier is an inline `*` whose registered result is counted out. Synthesis may retime it across MUL_CYCLES.

## Test plan
- MULT −3 × 7 (W=32, MUL_CYCLES=3) → `busy` for 3 cycles; at commit `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, one `done` pulse.
- DIVU 100 ÷ 7 → `done` exactly 33 cycles after `start`, with `lo`=14 and `hi`=2. DIV −100 ÷ 7 → `lo`=−14 (0xFFFFFFF2), `hi`=−2.
- DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU 5 ÷ 0 → same-edge commit with `lo`=0xFFFFFFFF, `hi`=5, and `done` plus `div_by_zero` pulse.
- MTHI 0x1234 and then MTLO 0x5678 on consecutive cycles → `hi`=0x1234 and `lo`=0x5678, two `done` pulses, `busy` never high.
- DIV started, `flush` at iteration 10 → IDLE the next cycle with `hi`/`lo` at prior values and no `done`; a subsequent MULTU 0xFFFFFFFF × 2 → `hi`=1, `lo`=0xFFFFFFFE.
- Drop `reset` low mid-DIV → `hi`, `lo`, `busy` and `done` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the HI/LO multiply/divide unit and the Control decode.
// Holds the unit's op codes, FSM state encoding and the funct -> op mapping.
// No logic of its own; the decode helper is purely combinational.
package mdu_pkg;

  // Unit operation codes, driven by Control alongside start
  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;
  localparam logic [2:0] MDU_NOP   = 3'b111;  // ignored by the unit

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Control-side decode: R-type ALUOp plus funct field
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // Returns MDU_NOP for anything that is not a multiply/divide/HI-LO write
  function automatic logic [2:0] mdu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [2:0] op;
    op = MDU_NOP;
    if (alu_op == ALUOP_RTYPE) begin
      case (funct)
        FUNCT_MULT:  op = MDU_MULT;
        FUNCT_MULTU: op = MDU_MULTU;
        FUNCT_DIV:   op = MDU_DIV;
        FUNCT_DIVU:  op = MDU_DIVU;
        FUNCT_MTHI:  op = MDU_MTHI;
        FUNCT_MTLO:  op = MDU_MTLO;
        default:     op = MDU_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// div_iter: restoring divider datapath, one quotient bit per cycle on operand magnitudes.
// Latency: WIDTH run cycles after load; last is high during the final iteration cycle.
// No backpressure: the parent gates run and simply abandons the datapath on flush.
// Ports: load/run control, is_signed, dividend/divisor in; last, sign-fixed quotient/remainder out.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;

  // The magnitude of the most negative value is still correct as an unsigned number
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // Quotient register doubles as the dividend shift register
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (load) begin
      quo_q     <= a_mag;
      rem_q     <= '0;
      dsr_q     <= b_mag;
      cnt_q     <= CW'(WIDTH);
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (run && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign last = (cnt_q == CW'(1));

  // Remainder follows the dividend's sign; min / -1 wraps back to min naturally
  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative HI/LO multiply/divide unit beside the EX-stage ALU.
// Latency: MUL_CYCLES for multiply, WIDTH+1 for divide, same edge for MTHI/MTLO and divide-by-zero.
// No backpressure: busy tells the hazard unit to stall; start while busy is ignored.
// Ports: start/op/in_1/in_2 issue, flush abort; busy, done, div_by_zero status; hi/lo registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MCW = $clog2(MUL_CYCLES + 1);

  logic [1:0]         state_q;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic               mul_signed_q;
  logic [MCW-1:0]     mul_cnt_q;
  logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, product;

  logic               is_div_op, div_load, div_run, div_last;
  logic [WIDTH-1:0]   div_quo, div_rem;

  // Extending both operands to 2W makes one multiplier serve signed and unsigned
  assign mul_ext_a = {{WIDTH{mul_signed_q & mul_a_q[WIDTH-1]}}, mul_a_q};
  assign mul_ext_b = {{WIDTH{mul_signed_q & mul_b_q[WIDTH-1]}}, mul_b_q};
  assign product   = mul_ext_a * mul_ext_b;

  assign is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
  assign div_load  = (state_q == ST_IDLE) && start && !flush && is_div_op && (in_2 != '0);
  assign div_run   = (state_q == ST_DIV) && !flush;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .run       (div_run),
    .is_signed (op == MDU_DIV),
    .dividend  (in_1),
    .divisor   (in_2),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
      div_by_zero  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
      mul_cnt_q    <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        // Abort wins over issue and over a pending FIX commit
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              case (op)
                MDU_MULT, MDU_MULTU: begin
                  mul_a_q      <= in_1;
                  mul_b_q      <= in_2;
                  mul_signed_q <= (op == MDU_MULT);
                  mul_cnt_q    <= MCW'(MUL_CYCLES - 1);
                  state_q      <= ST_MUL;
                end
                MDU_DIV, MDU_DIVU: begin
                  if (in_2 == '0) begin
                    lo          <= '1;
                    hi          <= in_1;
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                  end else begin
                    state_q <= ST_DIV;
                  end
                end
                MDU_MTHI: begin
                  hi   <= in_1;
                  done <= 1'b1;
                end
                MDU_MTLO: begin
                  lo   <= in_1;
                  done <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            if (mul_cnt_q == '0) begin
              hi      <= product[2*WIDTH-1:WIDTH];
              lo      <= product[WIDTH-1:0];
              done    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              mul_cnt_q <= mul_cnt_q - 1'b1;
            end
          end
          ST_DIV: begin
            if (div_last) state_q <= ST_FIX;
          end
          default: begin  // ST_FIX
            hi      <= div_rem;
            lo      <= div_quo;
            done    <= 1'b1;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] in_1 = '0;
  logic [W-1:0] in_2 = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural HI/LO as the reference model expects them
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .in_1        (in_1),
    .in_2        (in_2),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic; updates m_hi/m_lo as the architecture would
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic z, output int lat);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    z   = 1'b0;
    lat = -1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (o)
      MDU_MULT: begin
        p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0]; lat = MC;
      end
      MDU_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; lat = MC;
      end
      MDU_DIV, MDU_DIVU: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; z = 1'b1; lat = 0;
        end else if (o == MDU_DIV) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0]; lat = W + 1;
        end else begin
          m_lo = a / b; m_hi = a % b; lat = W + 1;
        end
      end
      MDU_MTHI: begin m_hi = a; lat = 0; end
      MDU_MTLO: begin m_lo = a; lat = 0; end
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit chk_drop);
    logic z;
    int   exp_lat, lat;
    bit   busy_ok;
    model(o, a, b, z, exp_lat);
    @(negedge clk);
    start = 1'b1; op = o; in_1 = a; in_2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " div_by_zero"}, div_by_zero, z);
    check({tag, " busy after commit"}, busy, 1'b0);
    check({tag, " busy while in flight"}, busy_ok, 1'b1);
    if (chk_drop) begin
      @(posedge clk); #1;
      check({tag, " done single pulse"}, done, 1'b0);
      check({tag, " div_by_zero single pulse"}, div_by_zero, 1'b0);
    end
  endtask

  // Issue a divide, flush it k edges after issue, then confirm nothing commits
  task automatic flush_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    int cnt;
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; in_1 = a; in_2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    check({tag, " busy before flush"}, busy, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check({tag, " busy after flush"}, busy, 1'b0);
    check({tag, " done after flush"}, done, 1'b0);
    check({tag, " hi kept"}, hi, m_hi);
    check({tag, " lo kept"}, lo, m_lo);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check({tag, " no late done"}, cnt, 0);
  endtask

  initial begin
    logic         z;
    int           el, lat;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;

    // Reset state
    #2;
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset div_by_zero", div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult -3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    check("mult -3x7 hi const", hi, 32'hFFFF_FFFF);
    check("mult -3x7 lo const", lo, 32'hFFFF_FFEB);

    run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 1'b1);
    check("divu 100/7 lo const", lo, 32'd14);
    check("divu 100/7 hi const", hi, 32'd2);

    run_op("div -100/7", MDU_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    check("div -100/7 lo const", lo, 32'hFFFF_FFF2);
    check("div -100/7 hi const", hi, 32'hFFFF_FFFE);

    run_op("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("div min/-1 lo const", lo, 32'h8000_0000);
    check("div min/-1 hi const", hi, 32'h0);

    run_op("divu 5/0", MDU_DIVU, 32'd5, 32'd0, 1'b1);
    check("divu 5/0 lo const", lo, 32'hFFFF_FFFF);
    check("divu 5/0 hi const", hi, 32'd5);

    // Consecutive HI/LO writes, the second issued in the first one's done cycle
    run_op("mthi", MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    run_op("mtlo", MDU_MTLO, 32'h5678, 32'd0, 1'b1);
    check("mthi/mtlo hi const", hi, 32'h1234);
    check("mthi/mtlo lo const", lo, 32'h5678);

    flush_div("flush iter10", 32'd1000, 32'd3, 10);
    run_op("multu ffffffffx2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("multu hi const", hi, 32'd1);
    check("multu lo const", lo, 32'hFFFF_FFFE);

    flush_div("flush in fix", 32'd77, 32'd5, W);

    // Flush together with start: the issue is dropped
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; in_1 = 32'hAAAA; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("start+flush done", done, 1'b0);
    check("start+flush hi", hi, m_hi);
    check("start+flush busy", busy, 1'b0);

    // Reserved op code
    @(negedge clk);
    start = 1'b1; op = 3'b110; in_1 = 32'h5555; in_2 = 32'h3;
    @(posedge clk); #1;
    start = 1'b0;
    check("op110 done", done, 1'b0);
    check("op110 busy", busy, 1'b0);
    check("op110 hi", hi, m_hi);
    check("op110 lo", lo, m_lo);

    // Start held during a multiply must be ignored
    model(MDU_MULT, 32'd5, 32'd6, z, el);
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; in_1 = 32'd5; in_2 = 32'd6;
    @(posedge clk); #1;
    op = MDU_MTLO; in_1 = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy-start latency", lat, el);
    check("busy-start hi", hi, m_hi);
    check("busy-start lo", lo, m_lo);

    // Randomised mix against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, bit'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a divide
    run_op("pre-reset mthi", MDU_MTHI, 32'hCAFE, 32'd0, 1'b0);
    run_op("pre-reset mtlo", MDU_MTLO, 32'hBEEF, 32'd0, 1'b1);
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; in_1 = 32'd900; in_2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre-reset busy", busy, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("async reset hi", hi, '0);
    check("async reset lo", lo, '0);
    check("async reset busy", busy, 1'b0);
    check("async reset done", done, 1'b0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    run_op("post-reset mult", MDU_MULT, 32'd12, 32'hFFFF_FFFE, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
